// File: rtl/tb_trace_checker.sv
// Trace checker: shadows a core's GPR/DM commits during a run, waits for pc to settle
// (or a timeout), then scans the shadows against a preloaded expectation table.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | accept expectation loads, wait for start
// S_RUN   | shadow commits, count cycles, watch pc for halt
// S_CHECK | scan one entry per cycle, GPRs then DM words
// S_DONE  | results held until the next start
module tb_trace_checker #(
    parameter int DW        = 32,
    parameter int NREG      = 32,
    parameter int MEM_WORDS = 16,
    parameter int TIMEOUT   = 300,
    parameter int STABLE    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   pc,
    input  logic          gpr_we,
    input  logic [4:0]    gpr_waddr,
    input  logic [DW-1:0] gpr_wdata,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic          exp_we,
    input  logic          exp_sel,
    input  logic [4:0]    exp_idx,
    input  logic [DW-1:0] exp_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [5:0]    err_cnt,
    output logic          first_err_sel,
    output logic [4:0]    first_err_idx,
    output logic [DW-1:0] first_err_got,
    output logic [15:0]   cycle_cnt
);
    localparam int GW   = $clog2(NREG);
    localparam int MW   = $clog2(MEM_WORDS);
    localparam int NENT = NREG + MEM_WORDS;
    localparam int CW   = $clog2(NENT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state;
    logic [31:0]    prev_pc;
    logic [15:0]    stab;
    logic [CW-1:0]  chk_idx;
    logic [DW-1:0]  sh_gpr  [NREG];
    logic [DW-1:0]  sh_dm   [MEM_WORDS];
    logic [DW-1:0]  exp_gpr [NREG];
    logic [DW-1:0]  exp_dm  [MEM_WORDS];
    logic [NREG-1:0]      exp_gpr_v;
    logic [MEM_WORDS-1:0] exp_dm_v;

    logic [15:0]   stab_nxt, cyc_nxt;
    logic          stab_hit, to_hit, gpr_ok, dm_ok;
    logic [31:0]   chk_i, dm_i;
    logic          in_gpr, chk_last, ent_v;
    logic [DW-1:0] ent_got, ent_exp;
    logic          unused_ok;

    assign stab_nxt = (pc == prev_pc) ? stab + 16'd1 : 16'd0;
    assign cyc_nxt  = cycle_cnt + 16'd1;
    assign stab_hit = 32'(stab_nxt) == 32'(STABLE - 1);
    assign to_hit   = 32'(cyc_nxt) == 32'(TIMEOUT);
    // r0 is hardwired zero in the traced core, so its commits never reach the shadow
    assign gpr_ok   = (32'(gpr_waddr) < 32'(NREG)) && (gpr_waddr != 5'd0);
    assign dm_ok    = 32'(dm_addr[31:2]) < 32'(MEM_WORDS);

    assign chk_i    = 32'(chk_idx);
    assign dm_i     = chk_i - 32'(NREG);
    assign in_gpr   = chk_i < 32'(NREG);
    assign chk_last = chk_i == 32'(NENT - 1);
    assign unused_ok = ^{dm_addr[1:0], dm_i[31:MW]};

    always_comb begin
        ent_v   = 1'b0;
        ent_got = '0;
        ent_exp = '0;
        if (in_gpr) begin
            ent_v   = exp_gpr_v[chk_i[GW-1:0]];
            ent_got = sh_gpr[chk_i[GW-1:0]];
            ent_exp = exp_gpr[chk_i[GW-1:0]];
        end else if (dm_i < 32'(MEM_WORDS)) begin
            ent_v   = exp_dm_v[dm_i[MW-1:0]];
            ent_got = sh_dm[dm_i[MW-1:0]];
            ent_exp = exp_dm[dm_i[MW-1:0]];
        end
    end

    assign busy = (state == S_RUN) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == 6'd0) && !timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            prev_pc       <= '0;
            stab          <= '0;
            chk_idx       <= '0;
            cycle_cnt     <= '0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            first_err_sel <= 1'b0;
            first_err_idx <= '0;
            first_err_got <= '0;
            exp_gpr_v     <= '0;
            exp_dm_v      <= '0;
            for (int i = 0; i < NREG; i++) begin
                sh_gpr[i]  <= '0;
                exp_gpr[i] <= '0;
            end
            for (int i = 0; i < MEM_WORDS; i++) begin
                sh_dm[i]  <= '0;
                exp_dm[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_IDLE && exp_we) begin
                        if (!exp_sel && (32'(exp_idx) < 32'(NREG))) begin
                            exp_gpr[exp_idx[GW-1:0]]   <= exp_data;
                            exp_gpr_v[exp_idx[GW-1:0]] <= 1'b1;
                        end else if (exp_sel && (32'(exp_idx) < 32'(MEM_WORDS))) begin
                            exp_dm[exp_idx[MW-1:0]]   <= exp_data;
                            exp_dm_v[exp_idx[MW-1:0]] <= 1'b1;
                        end
                    end
                    if (start) begin
                        state         <= S_RUN;
                        prev_pc       <= pc;
                        stab          <= '0;
                        chk_idx       <= '0;
                        cycle_cnt     <= '0;
                        timeout       <= 1'b0;
                        err_cnt       <= '0;
                        first_err_sel <= 1'b0;
                        first_err_idx <= '0;
                        first_err_got <= '0;
                        for (int i = 0; i < NREG; i++) sh_gpr[i] <= '0;
                        for (int i = 0; i < MEM_WORDS; i++) sh_dm[i] <= '0;
                    end
                end
                S_RUN: begin
                    cycle_cnt <= cyc_nxt;
                    stab      <= stab_nxt;
                    prev_pc   <= pc;
                    if (gpr_we && gpr_ok) sh_gpr[gpr_waddr[GW-1:0]] <= gpr_wdata;
                    if (dm_we && dm_ok) sh_dm[dm_addr[MW+1:2]] <= dm_wdata;
                    if (to_hit) begin
                        timeout <= 1'b1;
                        state   <= S_CHECK;
                    end else if (stab_hit) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (ent_v && (ent_got != ent_exp)) begin
                        if (err_cnt == 6'd0) begin
                            first_err_sel <= !in_gpr;
                            first_err_idx <= in_gpr ? 5'(chk_idx) : 5'(dm_i);
                            first_err_got <= ent_got;
                        end
                        if (err_cnt != 6'd63) err_cnt <= err_cnt + 6'd1;
                    end
                    if (chk_last) state <= S_DONE;
                    else chk_idx <= chk_idx + CW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tb_trace_checker.sv
// Directed bench for tb_trace_checker: each run's expected result is queued at start
// and compared when done rises; a 32-word-DM instance covers error-count saturation.
module tb_tb_trace_checker;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, gpr_we, dm_we, exp_we, exp_sel;
    logic [31:0]   pc, dm_addr;
    logic [4:0]    gpr_waddr, exp_idx;
    logic [DW-1:0] gpr_wdata, dm_wdata, exp_data;

    logic          busy, done, pass, timeout, first_err_sel;
    logic [5:0]    err_cnt;
    logic [4:0]    first_err_idx;
    logic [DW-1:0] first_err_got;
    logic [15:0]   cycle_cnt;

    logic          s_busy, s_done, s_pass, s_timeout, s_first_err_sel;
    logic [5:0]    s_err_cnt;
    logic [4:0]    s_first_err_idx;
    logic [DW-1:0] s_first_err_got;
    logic [15:0]   s_cycle_cnt;

    tb_trace_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .exp_we(exp_we), .exp_sel(exp_sel), .exp_idx(exp_idx), .exp_data(exp_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
        .first_err_sel(first_err_sel), .first_err_idx(first_err_idx),
        .first_err_got(first_err_got), .cycle_cnt(cycle_cnt)
    );

    tb_trace_checker #(.MEM_WORDS(32)) u_sat (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .exp_we(exp_we), .exp_sel(exp_sel), .exp_idx(exp_idx), .exp_data(exp_data),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .err_cnt(s_err_cnt),
        .first_err_sel(s_first_err_sel), .first_err_idx(s_first_err_idx),
        .first_err_got(s_first_err_got), .cycle_cnt(s_cycle_cnt)
    );

    typedef struct {
        logic          pass;
        logic          to;
        logic [5:0]    err;
        logic          sel;
        logic [4:0]    idx;
        logic [DW-1:0] got;
    } res_t;

    res_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic sel, input logic [4:0] idx, input logic [DW-1:0] data);
        exp_we = 1'b1; exp_sel = sel; exp_idx = idx; exp_data = data;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic push(input logic p, input logic to, input logic [5:0] err,
                        input logic sel, input logic [4:0] idx, input logic [DW-1:0] got);
        res_t e;
        e.pass = p; e.to = to; e.err = err; e.sel = sel; e.idx = idx; e.got = got;
        sb.push_back(e);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic sb_compare(input string tag);
        res_t e;
        e = sb.pop_front();
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_timeout"}, timeout, e.to);
        chk({tag, "_err_cnt"}, err_cnt, e.err);
        chk({tag, "_first_sel"}, first_err_sel, e.sel);
        chk({tag, "_first_idx"}, first_err_idx, e.idx);
        chk({tag, "_first_got"}, first_err_got, e.got);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, {busy, done, pass, timeout, first_err_sel}, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_first_idx"}, first_err_idx, 0);
        chk({tag, "_first_got"}, first_err_got, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; pc = 32'h100;
        gpr_we = 1'b0; gpr_waddr = '0; gpr_wdata = '0;
        dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        exp_we = 1'b0; exp_sel = 1'b0; exp_idx = '0; exp_data = '0;

        // basic pass: halt after 3 stable RUN cycles, then 48 CHECK cycles
        do_reset();
        chk_zero("reset");
        load(1'b0, 5'd8, 32'd5);
        load(1'b1, 5'd2, 32'hA);
        push(1'b1, 1'b0, 6'd0, 1'b0, 5'd0, '0);
        do_start();
        chk("busy_run", busy, 1);
        gpr_we = 1'b1; gpr_waddr = 5'd8; gpr_wdata = 32'd5;
        tick();
        gpr_we = 1'b0;
        dm_we = 1'b1; dm_addr = 32'd8; dm_wdata = 32'hA;
        tick();
        dm_we = 1'b0;
        wait_done(100, n);
        chk("halt_latency", n + 2, 51);
        chk("stable_cycle_cnt", cycle_cnt, 3);
        sb_compare("basic");

        // GPR mismatch with simultaneous matching DM write
        do_reset();
        load(1'b0, 5'd9, 32'd7);
        load(1'b1, 5'd1, 32'h55);
        push(1'b0, 1'b0, 6'd1, 1'b0, 5'd9, 32'd6);
        do_start();
        gpr_we = 1'b1; gpr_waddr = 5'd9; gpr_wdata = 32'd6;
        dm_we = 1'b1; dm_addr = 32'd4; dm_wdata = 32'h55;
        tick();
        gpr_we = 1'b0; dm_we = 1'b0;
        wait_done(100, n);
        sb_compare("mismatch");

        // r0 write and out-of-range DM write are both dropped
        do_reset();
        load(1'b0, 5'd0, 32'd0);
        load(1'b1, 5'd0, 32'd0);
        push(1'b1, 1'b0, 6'd0, 1'b0, 5'd0, '0);
        do_start();
        gpr_we = 1'b1; gpr_waddr = 5'd0; gpr_wdata = 32'hFFFF;
        dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hFFFF;
        tick();
        gpr_we = 1'b0; dm_we = 1'b0;
        wait_done(100, n);
        sb_compare("dropped");

        // pc never settles: timeout at 300 cycles
        do_reset();
        push(1'b0, 1'b1, 6'd0, 1'b0, 5'd0, '0);
        do_start();
        n = 0;
        while (!done && n < 500) begin
            pc = pc + 32'd4;
            tick();
            n++;
        end
        chk("timeout_done", done, 1);
        chk("timeout_cycle_cnt", cycle_cnt, 300);
        sb_compare("timeout");

        // reset mid-CHECK, then a clean run; stale valid bit for r7 must be gone
        do_reset();
        load(1'b0, 5'd7, 32'd9);
        do_start();
        repeat (10) tick();
        chk("busy_check", busy, 1);
        do_reset();
        chk_zero("rst_mid_check");
        load(1'b0, 5'd5, 32'd3);
        push(1'b1, 1'b0, 6'd0, 1'b0, 5'd0, '0);
        do_start();
        gpr_we = 1'b1; gpr_waddr = 5'd5; gpr_wdata = 32'd3;
        tick();
        gpr_we = 1'b0;
        wait_done(100, n);
        sb_compare("after_rst");

        // every entry expects 1, shadows stay 0; RUN-time exp_we must be ignored
        do_reset();
        for (int i = 0; i < 32; i++) load(1'b0, 5'(i), 32'd1);
        for (int i = 0; i < 32; i++) load(1'b1, 5'(i), 32'd1);
        push(1'b0, 1'b0, 6'd48, 1'b0, 5'd0, 32'd0);
        do_start();
        exp_we = 1'b1; exp_sel = 1'b0; exp_idx = 5'd3; exp_data = 32'd0;
        tick();
        exp_we = 1'b0;
        wait_done(100, n);
        sb_compare("many_err");
        n = 0;
        while (!s_done && n < 100) begin
            tick();
            n++;
        end
        chk("sat_done", s_done, 1);
        chk("sat_err_cnt", s_err_cnt, 63);
        chk("sat_pass", s_pass, 0);

        // restart from DONE: table retained, error record cleared
        push(1'b0, 1'b0, 6'd48, 1'b0, 5'd0, 32'd0);
        do_start();
        chk("restart_busy", busy, 1);
        wait_done(100, n);
        sb_compare("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
